// File: rtl/inst_rom_resp.sv
`default_nettype none
// ============================================================================
// Module   : inst_rom_resp
// Purpose  : Fully pipelined instruction-memory responder with side-band load
//            port. Define INST_ROM_ALIGN_CHECK_EN to flag misaligned fetches.
// Revision : 1.0 - initial release
// ============================================================================
module inst_rom_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chipEnable,
    input  logic [31:0]           pc,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  oor,
    output logic                  misaligned,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);
    localparam int          c_DEPTH     = 1 << DEPTH_LOG2;
    localparam int          c_STAGES    = WAIT_CYCLES + 1;
    localparam int          c_LAST      = c_STAGES - 1;
    localparam logic [31:0] c_ZERO_WORD = 32'h0000_0000;

    logic [31:0]           r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] w_word_idx;
    logic                  w_oor_req;
    logic                  w_mis_req;
    logic                  w_load_en;

    logic [c_STAGES-1:0]   r_valid_q, w_valid_d;
    logic [c_STAGES-1:0]   r_oor_q,   w_oor_d;
    logic [c_STAGES-1:0]   r_mis_q,   w_mis_d;
    logic [31:0]           r_data_q [c_STAGES];
    logic [31:0]           w_data_d [c_STAGES];

    assign w_word_idx = pc[DEPTH_LOG2+1:2];
    assign w_oor_req  = |pc[31:DEPTH_LOG2+2];

`ifdef INST_ROM_ALIGN_CHECK_EN
    assign w_mis_req = |pc[1:0];
`else
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = ^pc[1:0];
    assign w_mis_req       = 1'b0;
`endif

    // Loads are blocked while reset is held low.
    assign w_load_en = load_we & rst;

    always_ff @(posedge clk) begin
        if (w_load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        w_valid_d = '0;
        w_oor_d   = '0;
        w_mis_d   = '0;
        for (int i = 0; i < c_STAGES; i++) begin
            w_data_d[i] = c_ZERO_WORD;
        end
        // Stage 0 reads the array before any same-edge load lands.
        w_valid_d[0] = chipEnable;
        w_oor_d[0]   = w_oor_req;
        w_mis_d[0]   = w_mis_req;
        w_data_d[0]  = r_mem[w_word_idx];
        for (int i = 1; i < c_STAGES; i++) begin
            w_valid_d[i] = r_valid_q[i-1];
            w_oor_d[i]   = r_oor_q[i-1];
            w_mis_d[i]   = r_mis_q[i-1];
            w_data_d[i]  = r_data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_q <= '0;
            r_oor_q   <= '0;
            r_mis_q   <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_oor_q   <= w_oor_d;
            r_mis_q   <= w_mis_d;
        end
    end

    // Data is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        r_data_q <= w_data_d;
    end

    assign inst_valid = r_valid_q[c_LAST];
    assign oor        = r_valid_q[c_LAST] & r_oor_q[c_LAST];
    assign misaligned = r_valid_q[c_LAST] & r_mis_q[c_LAST];
    assign inst       = (r_valid_q[c_LAST] && !r_oor_q[c_LAST] && !r_mis_q[c_LAST])
                        ? r_data_q[c_LAST] : c_ZERO_WORD;

endmodule
`default_nettype wire
